// File: rtl/cart_mem_arb.sv
// cart_mem_arb
// Single-port cartridge-memory arbiter between the HPS download path and the
// emulated SCV bus. One download byte is buffered behind DL_WAIT. Bus accesses
// normally win arbitration, but a starvation counter forces a pending download
// entry through after two consecutive bus grants. The block also tracks the
// loaded image size and readiness for the cartridge mapper.
//
// Ports
//   CLK, RESB            : clock, synchronous active-low reset
//   DL_ACTIVE            : download in progress (rising edge starts a new image)
//   DL_WR/ADDR/DATA      : one-cycle download byte strobe
//   DL_WAIT              : holding register full, source must not strobe
//   DL_OVF               : sticky, a strobe arrived while DL_WAIT was high
//   BUS_REQ/WE/ADDR/WDATA: level bus request, held until BUS_ACK
//   BUS_RDATA, BUS_ACK   : read data and one-cycle completion pulse
//   MEM_*                : registered command to the shared synchronous RAM
//   MEM_RDATA            : RAM read data, RD_LAT cycles after MEM_RE
//   CART_SIZE            : highest download address + 1 (AW+1 bits, no wrap)
//   CART_READY           : image loaded and holding register drained
module cart_mem_arb #(
  parameter int AW     = 17,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RESB,
  input  logic          DL_ACTIVE,
  input  logic          DL_WR,
  input  logic [AW-1:0] DL_ADDR,
  input  logic [7:0]    DL_DATA,
  output logic          DL_WAIT,
  output logic          DL_OVF,
  input  logic          BUS_REQ,
  input  logic          BUS_WE,
  input  logic [AW-1:0] BUS_ADDR,
  input  logic [7:0]    BUS_WDATA,
  output logic [7:0]    BUS_RDATA,
  output logic          BUS_ACK,
  output logic [AW-1:0] MEM_ADDR,
  output logic [7:0]    MEM_WDATA,
  output logic          MEM_WE,
  output logic          MEM_RE,
  input  logic [7:0]    MEM_RDATA,
  output logic [AW:0]   CART_SIZE,
  output logic          CART_READY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  localparam logic [1:0] LAT_C = 2'(RD_LAT);
  localparam logic [AW:0] ONE_C = {{AW{1'b0}}, 1'b1};

  state_t        state_q;
  logic          wr_dl_q;      // current WR cycle serves the download entry
  logic [1:0]    lat_cnt_q;
  logic [1:0]    starve_q, starve_d;
  logic          full_q, full_d;
  logic [AW-1:0] hold_addr_q;
  logic [7:0]    hold_data_q;
  logic          dl_active_q;
  logic          dl_ovf_q, dl_ovf_d;
  logic [AW:0]   size_q, size_d;
  logic          ready_q, ready_d;
  logic [7:0]    bus_rdata_q;
  logic          bus_ack_q;
  logic [AW-1:0] mem_addr_q;
  logic [7:0]    mem_wdata_q;
  logic          mem_we_q, mem_re_q;

  logic          dl_acc_s, dl_pend_s, dl_rise_s, dl_done_s;
  logic          grant_bus_s, grant_dl_s;
  logic [AW-1:0] dl_addr_s;
  logic [7:0]    dl_data_s;
  logic [AW:0]   size_base_s, dl_size_s;

  // A strobe arriving with the register empty is pending in the same cycle,
  // so an idle memory can write it without a holding-register round trip.
  assign dl_acc_s    = DL_WR & ~full_q;
  assign dl_pend_s   = full_q | dl_acc_s;
  assign dl_addr_s   = full_q ? hold_addr_q : DL_ADDR;
  assign dl_data_s   = full_q ? hold_data_q : DL_DATA;
  assign dl_rise_s   = DL_ACTIVE & ~dl_active_q;
  assign dl_done_s   = (state_q == S_WR) & wr_dl_q;
  assign grant_bus_s = (state_q == S_IDLE) & BUS_REQ & ~(dl_pend_s & (starve_q == 2'd2));
  assign grant_dl_s  = (state_q == S_IDLE) & dl_pend_s & ~grant_bus_s;
  assign size_base_s = dl_rise_s ? '0 : size_q;
  assign dl_size_s   = {1'b0, DL_ADDR} + ONE_C;

  // Next-state for holding register, starvation counter, flags and size.
  always_comb begin
    full_d   = full_q;
    starve_d = starve_q;
    dl_ovf_d = dl_ovf_q;
    size_d   = size_base_s;
    ready_d  = ready_q;

    if (dl_acc_s) begin
      full_d = 1'b1;
    end else if (dl_done_s) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end

    if (grant_dl_s) begin
      starve_d = 2'd0;
    end else if (grant_bus_s && dl_pend_s) begin
      starve_d = starve_q + 2'd1;
    end else if (!dl_pend_s) begin
      starve_d = 2'd0;
    end else begin
      starve_d = starve_q;
    end

    // A dropped strobe outranks the clear so it is never lost.
    if (DL_WR && full_q) begin
      dl_ovf_d = 1'b1;
    end else if (dl_rise_s) begin
      dl_ovf_d = 1'b0;
    end else begin
      dl_ovf_d = dl_ovf_q;
    end

    if (dl_acc_s && (dl_size_s > size_base_s)) begin
      size_d = dl_size_s;
    end else begin
      size_d = size_base_s;
    end

    if (dl_rise_s) begin
      ready_d = 1'b0;
    end else if (!DL_ACTIVE && !full_q && !dl_done_s && (size_q != '0)) begin
      ready_d = 1'b1;
    end else begin
      ready_d = ready_q;
    end
  end

  // Download-side and status registers.
  always_ff @(posedge CLK) begin
    if (!RESB) begin
      full_q      <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= 8'h00;
      starve_q    <= 2'd0;
      dl_active_q <= 1'b0;
      dl_ovf_q    <= 1'b0;
      size_q      <= '0;
      ready_q     <= 1'b0;
    end else begin
      full_q      <= full_d;
      starve_q    <= starve_d;
      dl_active_q <= DL_ACTIVE;
      dl_ovf_q    <= dl_ovf_d;
      size_q      <= size_d;
      ready_q     <= ready_d;
      if (dl_acc_s) begin
        hold_addr_q <= DL_ADDR;
        hold_data_q <= DL_DATA;
      end
    end
  end

  // Memory sequencing FSM with registered memory and bus outputs.
  always_ff @(posedge CLK) begin
    if (!RESB) begin
      state_q     <= S_IDLE;
      wr_dl_q     <= 1'b0;
      lat_cnt_q   <= 2'd0;
      bus_rdata_q <= 8'h00;
      bus_ack_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      bus_ack_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_bus_s) begin
            mem_addr_q <= BUS_ADDR;
            wr_dl_q    <= 1'b0;
            if (BUS_WE) begin
              state_q     <= S_WR;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= BUS_WDATA;
            end else begin
              state_q   <= S_RD;
              mem_re_q  <= 1'b1;
              lat_cnt_q <= 2'd0;
            end
          end else if (grant_dl_s) begin
            state_q     <= S_WR;
            wr_dl_q     <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= dl_addr_s;
            mem_wdata_q <= dl_data_s;
          end
        end
        S_WR: begin
          wr_dl_q <= 1'b0;
          if (wr_dl_q) begin
            state_q <= S_IDLE;
          end else begin
            state_q   <= S_ACK;
            bus_ack_q <= 1'b1;
          end
        end
        S_RD: begin
          // First RD cycle carries MEM_RE; data arrives RD_LAT cycles later.
          if (lat_cnt_q == LAT_C) begin
            bus_rdata_q <= MEM_RDATA;
            bus_ack_q   <= 1'b1;
            state_q     <= S_ACK;
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign DL_WAIT    = full_q;
  assign DL_OVF     = dl_ovf_q;
  assign BUS_RDATA  = bus_rdata_q;
  assign BUS_ACK    = bus_ack_q;
  assign MEM_ADDR   = mem_addr_q;
  assign MEM_WDATA  = mem_wdata_q;
  assign MEM_WE     = mem_we_q;
  assign MEM_RE     = mem_re_q;
  assign CART_SIZE  = size_q;
  assign CART_READY = ready_q;

endmodule

// File: tb/tb_cart_mem_arb.sv
// Testbench for cart_mem_arb: directed stimulus, scoreboard queues for memory
// operations and bus acknowledges, checked by an independent monitor.
module tb_cart_mem_arb;
  localparam int AW     = 17;
  localparam int RD_LAT = 2;

  logic          CLK = 1'b0;
  logic          RESB;
  logic          DL_ACTIVE, DL_WR;
  logic [AW-1:0] DL_ADDR;
  logic [7:0]    DL_DATA;
  logic          DL_WAIT, DL_OVF;
  logic          BUS_REQ, BUS_WE;
  logic [AW-1:0] BUS_ADDR;
  logic [7:0]    BUS_WDATA, BUS_RDATA;
  logic          BUS_ACK;
  logic [AW-1:0] MEM_ADDR;
  logic [7:0]    MEM_WDATA;
  logic          MEM_WE, MEM_RE;
  logic [7:0]    MEM_RDATA;
  logic [AW:0]   CART_SIZE;
  logic          CART_READY;

  cart_mem_arb #(.AW(AW), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RESB(RESB), .DL_ACTIVE(DL_ACTIVE), .DL_WR(DL_WR),
    .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA), .DL_WAIT(DL_WAIT), .DL_OVF(DL_OVF),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE),
    .MEM_RE(MEM_RE), .MEM_RDATA(MEM_RDATA), .CART_SIZE(CART_SIZE),
    .CART_READY(CART_READY)
  );

  always #5 CLK = ~CLK;

  // Memory model: synchronous RAM with a two-stage read pipeline.
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rd_s1;
  logic       preload_en;
  always @(posedge CLK) begin
    if (preload_en) mem[17'h00100] <= 8'h3C;
    else if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
    if (MEM_RE) rd_s1 <= mem[MEM_ADDR];
    MEM_RDATA <= rd_s1;
  end

  typedef struct packed { logic is_wr; logic [AW-1:0] addr; logic [7:0] data; } memop_t;
  typedef struct packed { logic is_rd; logic [7:0] data; } ack_t;
  memop_t exp_mem [$];
  ack_t   exp_ack [$];
  memop_t mon_m;
  ack_t   mon_a;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues a memory op or an ack.
  always @(negedge CLK) begin
    if (MEM_WE || MEM_RE) begin
      if (exp_mem.size() == 0) begin
        chk_cnt++;
        $display("FAIL mem_unexpected: got we=%0b re=%0b addr=%0h data=%0h, expected no op",
                 MEM_WE, MEM_RE, MEM_ADDR, MEM_WDATA);
      end else begin
        mon_m = exp_mem.pop_front();
        chk("mem_we_re_excl", 32'(MEM_WE & MEM_RE), 32'd0);
        chk("mem_kind", 32'(MEM_WE), 32'(mon_m.is_wr));
        chk("mem_addr", 32'(MEM_ADDR), 32'(mon_m.addr));
        if (mon_m.is_wr) chk("mem_wdata", 32'(MEM_WDATA), 32'(mon_m.data));
      end
    end
    if (BUS_ACK) begin
      if (exp_ack.size() == 0) begin
        chk_cnt++;
        $display("FAIL ack_unexpected: got BUS_ACK=1 rdata=%0h, expected no ack", BUS_RDATA);
      end else begin
        mon_a = exp_ack.pop_front();
        if (mon_a.is_rd) chk("bus_rdata", 32'(BUS_RDATA), 32'(mon_a.data));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ack(input int max_cyc);
    int n;
    n = 1;
    tick();
    while (!BUS_ACK && n < max_cyc) begin
      tick();
      n++;
    end
    if (!BUS_ACK) begin
      chk_cnt++;
      $display("FAIL ack_timeout: got no BUS_ACK in %0d cycles, expected ack", max_cyc);
    end
  endtask

  task automatic dl_byte(input logic [AW-1:0] a, input logic [7:0] d);
    exp_mem.push_back({1'b1, a, d});
    DL_WR = 1'b1; DL_ADDR = a; DL_DATA = d;
    tick();
    DL_WR = 1'b0;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dl_wait"},    32'(DL_WAIT),    32'd0);
    chk({tag, "_dl_ovf"},     32'(DL_OVF),     32'd0);
    chk({tag, "_bus_ack"},    32'(BUS_ACK),    32'd0);
    chk({tag, "_bus_rdata"},  32'(BUS_RDATA),  32'd0);
    chk({tag, "_mem_we"},     32'(MEM_WE),     32'd0);
    chk({tag, "_mem_re"},     32'(MEM_RE),     32'd0);
    chk({tag, "_mem_addr"},   32'(MEM_ADDR),   32'd0);
    chk({tag, "_mem_wdata"},  32'(MEM_WDATA),  32'd0);
    chk({tag, "_cart_size"},  32'(CART_SIZE),  32'd0);
    chk({tag, "_cart_ready"}, 32'(CART_READY), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESB = 1'b0; preload_en = 1'b1;
    DL_ACTIVE = 1'b0; DL_WR = 1'b0; DL_ADDR = '0; DL_DATA = 8'h00;
    BUS_REQ = 1'b0; BUS_WE = 1'b0; BUS_ADDR = '0; BUS_WDATA = 8'h00;
    tick(); tick();
    check_reset_vals("reset");
    RESB = 1'b1; preload_en = 1'b0;
    tick();

    // Download burst 0..15, data = addr ^ 0x5A, with DL_WAIT timing on byte 0.
    DL_ACTIVE = 1'b1;
    tick();
    exp_mem.push_back({1'b1, 17'h00000, 8'h5A});
    DL_WR = 1'b1; DL_ADDR = '0; DL_DATA = 8'h5A;
    tick();
    DL_WR = 1'b0;
    chk("dl_wait_after_strobe", 32'(DL_WAIT), 32'd1);
    chk("dl_mem_we_after_strobe", 32'(MEM_WE), 32'd1);
    tick();
    chk("dl_wait_falls", 32'(DL_WAIT), 32'd0);
    for (int i = 1; i < 16; i++) dl_byte(17'(i), 8'(i) ^ 8'h5A);
    chk("ready_during_dl", 32'(CART_READY), 32'd0);
    DL_ACTIVE = 1'b0;
    tick(); tick();
    chk("burst_cart_size", 32'(CART_SIZE), 32'd16);
    chk("burst_cart_ready", 32'(CART_READY), 32'd1);

    // Read latency at RD_LAT=2: MEM_RE at k+1, ack at k+4 for one cycle.
    exp_mem.push_back({1'b0, 17'h00100, 8'h00});
    exp_ack.push_back({1'b1, 8'h3C});
    BUS_REQ = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 17'h00100;
    tick();
    chk("rd_mem_re_k1", 32'(MEM_RE), 32'd1);
    tick();
    chk("rd_no_ack_k2", 32'(BUS_ACK), 32'd0);
    tick();
    chk("rd_no_ack_k3", 32'(BUS_ACK), 32'd0);
    tick();
    chk("rd_ack_k4", 32'(BUS_ACK), 32'd1);
    chk("rd_data_k4", 32'(BUS_RDATA), 32'h3C);
    BUS_REQ = 1'b0;
    tick();
    chk("rd_ack_one_cycle", 32'(BUS_ACK), 32'd0);

    // Bus write then read-back.
    exp_mem.push_back({1'b1, 17'h00200, 8'hA5});
    exp_ack.push_back({1'b0, 8'h00});
    BUS_REQ = 1'b1; BUS_WE = 1'b1; BUS_ADDR = 17'h00200; BUS_WDATA = 8'hA5;
    tick();
    chk("wr_mem_we_k1", 32'(MEM_WE), 32'd1);
    tick();
    chk("wr_ack_k2", 32'(BUS_ACK), 32'd1);
    BUS_REQ = 1'b0;
    tick();
    exp_mem.push_back({1'b0, 17'h00200, 8'h00});
    exp_ack.push_back({1'b1, 8'hA5});
    BUS_REQ = 1'b1; BUS_WE = 1'b0;
    wait_ack(10);
    BUS_REQ = 1'b0;
    tick();

    // Starvation: reads held continuously, one download entry pending.
    DL_ACTIVE = 1'b1;
    tick();
    exp_mem.push_back({1'b0, 17'h00100, 8'h00});
    exp_mem.push_back({1'b0, 17'h00100, 8'h00});
    exp_mem.push_back({1'b1, 17'h00020, 8'h77});
    exp_mem.push_back({1'b0, 17'h00100, 8'h00});
    exp_mem.push_back({1'b0, 17'h00100, 8'h00});
    for (int i = 0; i < 4; i++) exp_ack.push_back({1'b1, 8'h3C});
    BUS_REQ = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 17'h00100;
    DL_WR = 1'b1; DL_ADDR = 17'h00020; DL_DATA = 8'h77;
    tick();
    DL_WR = 1'b0;
    chk("starve_bus_first", 32'(MEM_RE), 32'd1);
    chk("starve_dl_held", 32'(DL_WAIT), 32'd1);
    for (int n = 1; n <= 4; n++) begin
      wait_ack(20);
      if (n == 2) chk("starve_wait_after_2", 32'(DL_WAIT), 32'd1);
      if (n == 3) chk("starve_wait_after_3", 32'(DL_WAIT), 32'd0);
    end
    BUS_REQ = 1'b0;
    tick(); tick();

    // Overflow: strobe while DL_WAIT=1 is dropped and flagged.
    dl_byte(17'h00004, 8'h44);
    exp_mem.push_back({1'b1, 17'h00006, 8'h66});
    DL_WR = 1'b1; DL_ADDR = 17'h00006; DL_DATA = 8'h66;
    tick();
    chk("ovf_wait_high", 32'(DL_WAIT), 32'd1);
    DL_ADDR = 17'h00005; DL_DATA = 8'hFF;
    tick();
    DL_WR = 1'b0;
    chk("ovf_set", 32'(DL_OVF), 32'd1);
    tick(); tick();
    DL_ACTIVE = 1'b0;
    tick();
    chk("ovf_sticky", 32'(DL_OVF), 32'd1);
    DL_ACTIVE = 1'b1;
    tick();
    chk("ovf_cleared_by_rise", 32'(DL_OVF), 32'd0);

    // Boundary: top address gives 2^AW, then a new image resets size/ready.
    dl_byte(17'h1FFFF, 8'h11);
    DL_ACTIVE = 1'b0;
    tick(); tick();
    chk("max_cart_size", 32'(CART_SIZE), 32'h20000);
    chk("max_cart_ready", 32'(CART_READY), 32'd1);
    DL_ACTIVE = 1'b1;
    tick();
    chk("rise_ready_drop", 32'(CART_READY), 32'd0);
    chk("rise_size_clear", 32'(CART_SIZE), 32'd0);
    for (int i = 0; i < 4; i++) dl_byte(17'(3 - i), 8'(i) ^ 8'h5A);
    DL_ACTIVE = 1'b0;
    tick(); tick();
    chk("small_cart_size", 32'(CART_SIZE), 32'd4);
    chk("small_cart_ready", 32'(CART_READY), 32'd1);

    // Reset in the MEM_RE cycle: no ack, outputs back to reset values.
    exp_mem.push_back({1'b0, 17'h00100, 8'h00});
    BUS_REQ = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 17'h00100;
    tick();
    chk("midrd_mem_re", 32'(MEM_RE), 32'd1);
    RESB = 1'b0; BUS_REQ = 1'b0;
    tick();
    check_reset_vals("midrd");
    RESB = 1'b1;
    tick(); tick(); tick();
    chk("midrd_no_ack", 32'(BUS_ACK), 32'd0);
    exp_mem.push_back({1'b1, 17'h00300, 8'h5C});
    exp_ack.push_back({1'b0, 8'h00});
    BUS_REQ = 1'b1; BUS_WE = 1'b1; BUS_ADDR = 17'h00300; BUS_WDATA = 8'h5C;
    tick();
    chk("post_rst_idle_we", 32'(MEM_WE), 32'd1);
    tick();
    chk("post_rst_ack", 32'(BUS_ACK), 32'd1);
    BUS_REQ = 1'b0;
    repeat (5) tick();

    chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
    chk("ack_queue_empty", 32'(exp_ack.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
